systolic_input_sequencer: RTL
=============================

Name: systolic_input_sequencer

Overview:
Drives the input side of the 2x2 systolic array top level. It loads the four PE weights in one cycle, then streams activation vectors every cycle with the diagonal skew applied in hardware: lane 2 is delayed one cycle behind lane 1. It finishes with flush cycles so the accumulators complete. It sits between the host/buffer side (valid/ready vector stream) and the array's load_weight/valid/a_in ports, and replaces hand-timed stimulus.

Parameters:
DATA_W, 16, width of weights and activations
FIFO_DEPTH, 4, activation vector buffer depth (power of 2, >=2)
MAX_VEC, 255, max vectors per batch; count width CNT_W = clog2(MAX_VEC+1)
DRAIN_CYCLES, 2, zero-valued valid cycles after skew drain

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  begin batch; sampled only in IDLE
num_vec  in  CNT_W  vectors in batch, sampled with start
weight1..weight4  in  DATA_W each  PE(0,0),(0,1),(1,0),(1,1) weights, sampled with start
vec_valid  in  1  input vector valid
vec_ready  out  1  = FIFO not full
vec_a1  in  DATA_W  lane-1 element (row 1) of vector k
vec_a2  in  DATA_W  lane-2 element (row 2) of vector k
load_weight  out  1  to array
weight_out1..4  out  DATA_W each  to array weight1..4
valid  out  1  to array
a_in1  out  DATA_W  to array, row 1
a_in2  out  DATA_W  to array, row 2 (skewed)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at batch end

Behaviour:
- All outputs are registered. On reset: every output = 0, FSM = IDLE, FIFO empty, skew register = 0, count = 0.
- Push: vec_valid && vec_ready on a rising edge. Pushing is allowed in every state, so the FIFO can prefill in IDLE. When the FIFO is full, vec_ready = 0, even if a pop occurs in the same cycle.
- IDLE: valid = 0, load_weight = 0. If start is high, latch the weights and num_vec, then go to LOAD. If busy, start is ignored.
- LOAD, one cycle:
  - load_weight = 1 and weight_out = latched weights; valid = 0.
  - If num_vec == 0, go to DONE. Otherwise go to STREAM.
- STREAM:
  - FIFO non-empty: pop; a_in1 = vec_a1; a_in2 = skew_reg; skew_reg <= vec_a2; valid = 1; count++. After pop number num_vec, go to FLUSH.
  - FIFO empty (bubble): valid = 0; a_in1, a_in2 and skew_reg hold. The array freezes on valid = 0, which preserves alignment.
- FLUSH, 1 + DRAIN_CYCLES cycles, all with valid = 1:
  - First cycle: a_in1 = 0, a_in2 = skew_reg, then skew_reg <= 0.
  - Remaining cycles: a_in1 = a_in2 = 0.
  - Then go to DONE.
- DONE, one cycle: done = 1, valid = 0, a_in = 0, count cleared. Then go to IDLE.
- Latency: start at edge E0 → load_weight is high in the cycle after E0. The first vector appears one cycle later if the FIFO was prefilled.
- Vectors pushed beyond num_vec stay in the FIFO for the next batch.
- load_weight is high only in LOAD. weight_out holds the latched values after LOAD.
- Reset mid-batch: immediate return to the reset state; no done pulse.
- Arithmetic: the counter has no wrap; num_vec > MAX_VEC cannot occur by width.

Decomposition:
- Shared package holds:
  - DATA_W default
  - FSM state enum: IDLE, LOAD, STREAM, FLUSH, DONE
  - a 2-lane vector struct {a1, a2}
- One sub-module: sync_fifo (parameterised width/depth, outputs full/empty). Its width is 2*DATA_W and it is reused by the later output deskew block.
- The FSM, skew register and counter live in the top.

Test Plan:
- Canonical batch: prefill (11,21),(12,22); weights 3,5,4,6; start with num_vec = 2. Required response:
  - load_weight is high for exactly 1 cycle.
  - (a_in1, a_in2) per cycle: (11,0), (12,21), (0,22), (0,0), (0,0), all with valid = 1.
  - done pulses once; array accumulators acc_out1 = 11·3+12·4 = 81, acc_out2 = 21·5+22·6 = 237 per the array's mapping.
- Bubble: push (1,2) before start; push (3,4) three cycles late. Required response:
  - Output stream (1,0), then valid = 0 for the bubble cycles with outputs held, then (3,2), (0,4), (0,0), (0,0).
- Backpressure: push 6 vectors back-to-back while IDLE. Required response:
  - vec_ready drops after 4 pushes; exactly 4 are accepted.
  - After start with num_vec = 6, all 6 stream in order, with no loss or duplication.
- num_vec = 0: one load_weight cycle, then done; valid is never high, and FIFO contents are untouched.
- Reset mid-STREAM: assert reset after the 1st vector of 4. Required response:
  - All outputs are 0 immediately, with no done pulse.
  - FIFO is empty and busy = 0.
  - A new batch afterward behaves identically to the canonical batch.
- start while busy: assert start during STREAM with different weights. Required response:
  - Ignored; weight_out is unchanged, and exactly one done pulse occurs.

Source files
------------

// File: rtl/systolic_input_sequencer_pkg.sv
// Shared types for the 2x2 systolic array input side: sequencer states,
// the two-lane activation vector and a small packing helper.
package systolic_input_sequencer_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] a1;
    logic [DEF_DATA_W-1:0] a2;
  } vec2_t;

  function automatic vec2_t make_vec(input logic [DEF_DATA_W-1:0] a1,
                                     input logic [DEF_DATA_W-1:0] a2);
    vec2_t v;
    v.a1 = a1;
    v.a2 = a2;
    return v;
  endfunction

endpackage

// File: rtl/systolic_input_sequencer_fifo.sv
// Generic show-ahead synchronous FIFO. The head entry is always visible on
// o_rdata; pushes into a full FIFO and pops from an empty one are dropped.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Advance the read/write pointers on accepted transfers; reset empties the FIFO.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/systolic_input_sequencer.sv
// Input sequencer for the 2x2 systolic array: loads the four PE weights in a
// single cycle, streams buffered activation vectors with lane 2 skewed one
// cycle behind lane 1, then flushes zeros so the accumulators complete.
// A cycle with valid low is a bubble: the array freezes and the skew
// alignment is preserved because a_in and the skew register hold.
module systolic_input_sequencer
  import systolic_input_sequencer_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_VEC      = 255,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = $clog2(MAX_VEC + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_num_vec,
  input  logic [DATA_W-1:0] i_weight1,
  input  logic [DATA_W-1:0] i_weight2,
  input  logic [DATA_W-1:0] i_weight3,
  input  logic [DATA_W-1:0] i_weight4,
  input  logic              i_vec_valid,
  output logic              o_vec_ready,
  input  logic [DATA_W-1:0] i_vec_a1,
  input  logic [DATA_W-1:0] i_vec_a2,
  output logic              o_load_weight,
  output logic [DATA_W-1:0] o_weight_out1,
  output logic [DATA_W-1:0] o_weight_out2,
  output logic [DATA_W-1:0] o_weight_out3,
  output logic [DATA_W-1:0] o_weight_out4,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_a_in1,
  output logic [DATA_W-1:0] o_a_in2,
  output logic              o_busy,
  output logic              o_done
);

  localparam int DRN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYCLES);
  localparam logic [DRN_W-1:0] DRN_ONE    = 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = 1;

  seq_state_t          r_state;
  logic [CNT_W-1:0]    r_num_vec;
  logic [CNT_W-1:0]    r_count;
  logic [DRN_W-1:0]    r_drain;
  logic [DATA_W-1:0]   r_skew;

  logic [2*DATA_W-1:0] w_fifo_wdata;
  logic [2*DATA_W-1:0] w_fifo_rdata;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic [DATA_W-1:0]   w_head_a1;
  logic [DATA_W-1:0]   w_head_a2;
  logic [CNT_W-1:0]    w_count_inc;

  assign w_fifo_wdata = {i_vec_a1, i_vec_a2};
  assign w_head_a1    = w_fifo_rdata[2*DATA_W-1:DATA_W];
  assign w_head_a2    = w_fifo_rdata[DATA_W-1:0];
  assign w_pop        = (r_state == ST_STREAM) && !w_fifo_empty;
  assign w_count_inc  = r_count + CNT_ONE;
  assign o_vec_ready  = !w_fifo_full;

  sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_vec_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_vec_valid),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Batch FSM with registered array-side outputs, skew register and vector counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_num_vec     <= '0;
      r_count       <= '0;
      r_drain       <= '0;
      r_skew        <= '0;
      o_load_weight <= 1'b0;
      o_weight_out1 <= '0;
      o_weight_out2 <= '0;
      o_weight_out3 <= '0;
      o_weight_out4 <= '0;
      o_valid       <= 1'b0;
      o_a_in1       <= '0;
      o_a_in2       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done        <= 1'b0;
          o_valid       <= 1'b0;
          o_load_weight <= 1'b0;
          if (i_start) begin
            o_weight_out1 <= i_weight1;
            o_weight_out2 <= i_weight2;
            o_weight_out3 <= i_weight3;
            o_weight_out4 <= i_weight4;
            r_num_vec     <= i_num_vec;
            o_load_weight <= 1'b1;
            o_busy        <= 1'b1;
            r_state       <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          o_load_weight <= 1'b0;
          o_valid       <= 1'b0;
          if (r_num_vec == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (!w_fifo_empty) begin
            o_a_in1 <= w_head_a1;
            o_a_in2 <= r_skew;
            r_skew  <= w_head_a2;
            o_valid <= 1'b1;
            r_count <= w_count_inc;
            if (w_count_inc == r_num_vec) begin
              r_drain <= '0;
              r_state <= ST_FLUSH;
            end
          end else begin
            o_valid <= 1'b0;
          end
        end

        ST_FLUSH: begin
          o_valid <= 1'b1;
          o_a_in1 <= '0;
          if (r_drain == '0) begin
            o_a_in2 <= r_skew;
            r_skew  <= '0;
          end else begin
            o_a_in2 <= '0;
          end
          if (r_drain == DRAIN_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_drain <= r_drain + DRN_ONE;
          end
        end

        ST_DONE: begin
          o_done  <= 1'b1;
          o_valid <= 1'b0;
          o_a_in1 <= '0;
          o_a_in2 <= '0;
          o_busy  <= 1'b0;
          r_count <= '0;
          r_drain <= '0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
